add_rs_dispatch: RTL and testbench

//  Add/sub reservation station and dispatcher: the sending end of the add execution-unit interface.

---
 rtl/add_rs_dispatch.sv | 166 ++++++++++++++++
 tb/tb_add_rs_dispatch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station: holds issued ops until both operands are known,
// snoops the CDB for wakeup and hands one ready op at a time to the add unit.
module add_rs_dispatch #(
  parameter int RS_DEPTH = 3,
  parameter int DW       = 8
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [3:0]    iss_func,
  input  logic [3:0]    iss_rd,
  input  logic [2:0]    iss_rob,
  input  logic          iss_s1_rdy,
  input  logic [3:0]    iss_s1_tag,
  input  logic [DW-1:0] iss_s1_val,
  input  logic          iss_s2_rdy,
  input  logic [3:0]    iss_s2_tag,
  input  logic [DW-1:0] iss_s2_val,
  input  logic          cdb_valid,
  input  logic [3:0]    cdb_rd,
  input  logic [DW-1:0] cdb_data,
  input  logic          ex_done,
  output logic          ex_b,
  output logic [2:0]    rs_index,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    func,
  output logic [2:0]    rob_ind,
  output logic [3:0]    rd,
  output logic [2:0]    add_count
);

  localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef struct packed {
    logic [3:0]    func;
    logic [3:0]    rd;
    logic [2:0]    rob;
    logic          s1_rdy;
    logic [3:0]    s1_tag;
    logic [DW-1:0] s1_val;
    logic          s2_rdy;
    logic [3:0]    s2_tag;
    logic [DW-1:0] s2_val;
  } entry_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_next;
  logic [RS_DEPTH-1:0]  ent_valid;
  entry_t               ents [RS_DEPTH];
  entry_t               iss_entry;
  logic [IW-1:0]        free_idx, ready_idx;
  logic                 has_free, has_ready;
  logic                 issue_go, dispatch_go;

  // Lowest free slot for issue and lowest fully-ready slot for dispatch.
  always_comb begin
    free_idx  = '0;
    has_free  = 1'b0;
    ready_idx = '0;
    has_ready = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_idx = IW'(i);
        has_free = 1'b1;
      end
      if (ent_valid[i] && ents[i].s1_rdy && ents[i].s2_rdy) begin
        ready_idx = IW'(i);
        has_ready = 1'b1;
      end
    end
  end

  assign iss_ready = has_free;
  assign issue_go  = iss_valid & has_free;

  // An op arriving alongside a matching broadcast must not miss it.
  always_comb begin
    iss_entry.func   = iss_func;
    iss_entry.rd     = iss_rd;
    iss_entry.rob    = iss_rob;
    iss_entry.s1_rdy = iss_s1_rdy;
    iss_entry.s1_tag = iss_s1_tag;
    iss_entry.s1_val = iss_s1_val;
    iss_entry.s2_rdy = iss_s2_rdy;
    iss_entry.s2_tag = iss_s2_tag;
    iss_entry.s2_val = iss_s2_val;
    if (cdb_valid && !iss_s1_rdy && (iss_s1_tag == cdb_rd)) begin
      iss_entry.s1_rdy = 1'b1;
      iss_entry.s1_val = cdb_data;
    end
    if (cdb_valid && !iss_s2_rdy && (iss_s2_tag == cdb_rd)) begin
      iss_entry.s2_rdy = 1'b1;
      iss_entry.s2_val = cdb_data;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (has_ready) state_next = BUSY;
      BUSY:    if (ex_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dispatch_go = 1'b0;
    if (state == IDLE) dispatch_go = has_ready;
  end

  // Station storage, wakeup, and the registered dispatch port.
  always_ff @(posedge clk2) begin
    if (rst) begin
      ent_valid <= '0;
      ex_b      <= 1'b0;
      rs_index  <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      func      <= '0;
      rob_ind   <= '0;
      rd        <= '0;
      add_count <= '0;
    end else begin
      ex_b <= dispatch_go;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ent_valid[i] && cdb_valid) begin
          if (!ents[i].s1_rdy && (ents[i].s1_tag == cdb_rd)) begin
            ents[i].s1_rdy <= 1'b1;
            ents[i].s1_val <= cdb_data;
          end
          if (!ents[i].s2_rdy && (ents[i].s2_tag == cdb_rd)) begin
            ents[i].s2_rdy <= 1'b1;
            ents[i].s2_val <= cdb_data;
          end
        end
      end
      if (issue_go) begin
        ent_valid[free_idx] <= 1'b1;
        ents[free_idx]      <= iss_entry;
      end
      if (dispatch_go) begin
        ent_valid[ready_idx] <= 1'b0;
        rs_index             <= 3'(ready_idx);
        rs1_data             <= ents[ready_idx].s1_val;
        rs2_data             <= ents[ready_idx].s2_val;
        func                 <= ents[ready_idx].func;
        rob_ind              <= ents[ready_idx].rob;
        rd                   <= ents[ready_idx].rd;
      end
      case ({issue_go, dispatch_go})
        2'b10:   add_count <= add_count + 3'd1;
        2'b01:   add_count <= add_count - 3'd1;
        default: add_count <= add_count;
      endcase
    end
  end

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Self-checking bench for add_rs_dispatch: table-driven single-op vectors plus
// directed multi-cycle sequences, dispatches checked against a scoreboard queue.
module tb_add_rs_dispatch;

  logic       clk2 = 1'b0;
  logic       rst = 1'b1;
  logic       iss_valid = 1'b0;
  logic       iss_ready;
  logic [3:0] iss_func = '0, iss_rd = '0;
  logic [2:0] iss_rob = '0;
  logic       iss_s1_rdy = 1'b0, iss_s2_rdy = 1'b0;
  logic [3:0] iss_s1_tag = '0, iss_s2_tag = '0;
  logic [7:0] iss_s1_val = '0, iss_s2_val = '0;
  logic       cdb_valid = 1'b0;
  logic [3:0] cdb_rd = '0;
  logic [7:0] cdb_data = '0;
  logic       ex_done = 1'b0;
  logic       ex_b;
  logic [2:0] rs_index, rob_ind, add_count;
  logic [7:0] rs1_data, rs2_data;
  logic [3:0] func, rd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [29:0] exp_q[$];

  add_rs_dispatch #(.RS_DEPTH(3), .DW(8)) dut (
    .clk2(clk2), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_s1_rdy(iss_s1_rdy), .iss_s1_tag(iss_s1_tag), .iss_s1_val(iss_s1_val),
    .iss_s2_rdy(iss_s2_rdy), .iss_s2_tag(iss_s2_tag), .iss_s2_val(iss_s2_val),
    .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
    .ex_done(ex_done), .ex_b(ex_b), .rs_index(rs_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func),
    .rob_ind(rob_ind), .rd(rd), .add_count(add_count)
  );

  always #5 clk2 = ~clk2;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic [3:0] func; logic [3:0] rd; logic [2:0] rob;
    logic s1_rdy; logic [3:0] s1_tag; logic [7:0] s1_val;
    logic s2_rdy; logic [3:0] s2_tag; logic [7:0] s2_val;
    logic cdb_v; logic [3:0] cdb_rd; logic [7:0] cdb_data;
    logic [7:0] exp_rs1; logic [7:0] exp_rs2;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic pushExp(input logic [2:0] idx, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [3:0] f, input logic [2:0] rob, input logic [3:0] d);
    exp_q.push_back({idx, r1, r2, f, rob, d});
  endtask

  // Drives one issue cycle; CDB inputs are set separately by the caller.
  task automatic applyStimulus(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rob,
                               input logic r1, input logic [3:0] t1, input logic [7:0] v1,
                               input logic r2, input logic [3:0] t2, input logic [7:0] v2);
    iss_func = f; iss_rd = d; iss_rob = rob;
    iss_s1_rdy = r1; iss_s1_tag = t1; iss_s1_val = v1;
    iss_s2_rdy = r2; iss_s2_tag = t2; iss_s2_val = v2;
    iss_valid = 1'b1;
    step();
    iss_valid = 1'b0;
  endtask

  task automatic finishEx();
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
  endtask

  // Frees the unit then waits (bounded) for the next dispatch strobe.
  task automatic drain(input string name);
    logic seen;
    seen = 1'b0;
    finishEx();
    for (int k = 0; k < 6 && !seen; k++) begin
      step();
      if (ex_b) seen = 1'b1;
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  always @(negedge clk2) begin
    if (!rst && ex_b === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_dispatch", {2'b0, rs_index, rs1_data, rs2_data, func, rob_ind, rd}, 32'h0);
      end else begin
        checkOutput("dispatch_record", {2'b0, rs_index, rs1_data, rs2_data, func, rob_ind, rd},
                    {2'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    vecs[0] = '{4'h0, 4'd1, 3'd0, 1, 4'd0, 8'h10, 1, 4'd0, 8'h20, 0, 4'd0, 8'h00, 8'h10, 8'h20};
    vecs[1] = '{4'h1, 4'd2, 3'd5, 1, 4'd7, 8'h33, 1, 4'd0, 8'h44, 1, 4'd7, 8'hEE, 8'h33, 8'h44};
    vecs[2] = '{4'hF, 4'd9, 3'd7, 0, 4'd3, 8'h00, 0, 4'd3, 8'h00, 1, 4'd3, 8'h5A, 8'h5A, 8'h5A};
    vecs[3] = '{4'h0, 4'd0, 3'd2, 1, 4'd0, 8'hFF, 0, 4'd8, 8'h00, 1, 4'd8, 8'h01, 8'hFF, 8'h01};
    vecs[4] = '{4'h1, 4'd4, 3'd6, 1, 4'd0, 8'h00, 1, 4'd0, 8'h80, 0, 4'd0, 8'h00, 8'h00, 8'h80};

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checkOutput("reset_ex_b", {31'd0, ex_b}, 32'd0);
    checkOutput("reset_count", {29'd0, add_count}, 32'd0);
    checkOutput("reset_iss_ready", {31'd0, iss_ready}, 32'd1);
    checkOutput("reset_data", {rs1_data, rs2_data, func, rd, 2'b0, rob_ind, rs_index}, 32'd0);

    $display("[TB] test 1: ready add dispatches next cycle");
    pushExp(3'd0, 8'd5, 8'd7, 4'h0, 3'd1, 4'd3);
    applyStimulus(4'h0, 4'd3, 3'd1, 1, 4'd0, 8'd5, 1, 4'd0, 8'd7);
    checkOutput("t1_count_after_issue", {29'd0, add_count}, 32'd1);
    checkOutput("t1_no_early_ex_b", {31'd0, ex_b}, 32'd0);
    step();
    checkOutput("t1_ex_b", {31'd0, ex_b}, 32'd1);
    checkOutput("t1_count_after_disp", {29'd0, add_count}, 32'd0);
    step();
    checkOutput("t1_ex_b_one_cycle", {31'd0, ex_b}, 32'd0);
    checkOutput("t1_data_hold", {24'd0, rs1_data}, 32'd5);
    finishEx();

    $display("[TB] test 2: wakeup from CDB two cycles after issue");
    pushExp(3'd0, 8'd3, 8'd9, 4'h1, 3'd2, 4'd4);
    applyStimulus(4'h1, 4'd4, 3'd2, 1, 4'd0, 8'd3, 0, 4'd2, 8'd0);
    step();
    checkOutput("t2_wait_ex_b_a", {31'd0, ex_b}, 32'd0);
    cdb_valid = 1'b1; cdb_rd = 4'd2; cdb_data = 8'd9;
    step();
    cdb_valid = 1'b0;
    checkOutput("t2_wait_ex_b_b", {31'd0, ex_b}, 32'd0);
    step();
    checkOutput("t2_ex_b", {31'd0, ex_b}, 32'd1);
    checkOutput("t2_rs2_data", {24'd0, rs2_data}, 32'd9);
    step();
    finishEx();

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      pushExp(3'd0, vecs[i].exp_rs1, vecs[i].exp_rs2, vecs[i].func, vecs[i].rob, vecs[i].rd);
      cdb_valid = vecs[i].cdb_v; cdb_rd = vecs[i].cdb_rd; cdb_data = vecs[i].cdb_data;
      applyStimulus(vecs[i].func, vecs[i].rd, vecs[i].rob,
                    vecs[i].s1_rdy, vecs[i].s1_tag, vecs[i].s1_val,
                    vecs[i].s2_rdy, vecs[i].s2_tag, vecs[i].s2_val);
      cdb_valid = 1'b0;
      checkOutput("vec_count", {29'd0, add_count}, 32'd1);
      step();
      checkOutput("vec_ex_b", {31'd0, ex_b}, 32'd1);
      step();
      finishEx();
    end

    $display("[TB] test 3: full station holds off the fourth op");
    pushExp(3'd0, 8'h11, 8'h02, 4'h0, 3'd1, 4'd1);
    pushExp(3'd0, 8'h20, 8'h21, 4'h0, 3'd4, 4'd15);
    pushExp(3'd1, 8'h11, 8'h03, 4'h1, 3'd2, 4'd2);
    pushExp(3'd2, 8'h04, 8'h11, 4'h5, 3'd3, 4'd3);
    applyStimulus(4'h0, 4'd1, 3'd1, 0, 4'd10, 8'h00, 1, 4'd0, 8'h02);
    applyStimulus(4'h1, 4'd2, 3'd2, 0, 4'd10, 8'h00, 1, 4'd0, 8'h03);
    applyStimulus(4'h5, 4'd3, 3'd3, 1, 4'd0, 8'h04, 0, 4'd10, 8'h00);
    checkOutput("t3_full_count", {29'd0, add_count}, 32'd3);
    checkOutput("t3_full_not_ready", {31'd0, iss_ready}, 32'd0);
    iss_func = 4'h0; iss_rd = 4'd15; iss_rob = 3'd4;
    iss_s1_rdy = 1; iss_s1_val = 8'h20; iss_s2_rdy = 1; iss_s2_val = 8'h21;
    iss_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput("t3_hold_count", {29'd0, add_count}, 32'd3);
      checkOutput("t3_hold_no_ex_b", {31'd0, ex_b}, 32'd0);
    end
    cdb_valid = 1'b1; cdb_rd = 4'd10; cdb_data = 8'h11;
    step();
    cdb_valid = 1'b0;
    checkOutput("t3_wake_count", {29'd0, add_count}, 32'd3);
    step();
    checkOutput("t3_first_ex_b", {31'd0, ex_b}, 32'd1);
    checkOutput("t3_freed_ready", {31'd0, iss_ready}, 32'd1);
    checkOutput("t3_count_after_disp", {29'd0, add_count}, 32'd2);
    step();
    iss_valid = 1'b0;
    checkOutput("t3_fourth_accepted", {29'd0, add_count}, 32'd3);
    drain("t3_drain_d");
    drain("t3_drain_b");
    drain("t3_drain_c");
    step();
    finishEx();

    $display("[TB] test 4: second ready op waits for ex_done");
    pushExp(3'd0, 8'h01, 8'h02, 4'h0, 3'd5, 4'd5);
    pushExp(3'd1, 8'h09, 8'h03, 4'h1, 3'd6, 4'd6);
    applyStimulus(4'h0, 4'd5, 3'd5, 1, 4'd0, 8'h01, 1, 4'd0, 8'h02);
    applyStimulus(4'h1, 4'd6, 3'd6, 1, 4'd0, 8'h09, 1, 4'd0, 8'h03);
    checkOutput("t4_first_ex_b", {31'd0, ex_b}, 32'd1);
    checkOutput("t4_count_issue_and_disp", {29'd0, add_count}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("t4_busy_no_ex_b", {31'd0, ex_b}, 32'd0);
    end
    finishEx();
    checkOutput("t4_done_edge_no_ex_b", {31'd0, ex_b}, 32'd0);
    step();
    checkOutput("t4_second_ex_b", {31'd0, ex_b}, 32'd1);
    checkOutput("t4_second_index", {29'd0, rs_index}, 32'd1);
    checkOutput("t4_count_empty", {29'd0, add_count}, 32'd0);
    step();
    finishEx();

    $display("[TB] test 5: issue/broadcast bypass");
    pushExp(3'd0, 8'hAA, 8'h01, 4'h0, 3'd3, 4'd7);
    cdb_valid = 1'b1; cdb_rd = 4'd6; cdb_data = 8'hAA;
    applyStimulus(4'h0, 4'd7, 3'd3, 0, 4'd6, 8'h00, 1, 4'd0, 8'h01);
    cdb_valid = 1'b0;
    step();
    checkOutput("t5_ex_b", {31'd0, ex_b}, 32'd1);
    checkOutput("t5_rs1_data", {24'd0, rs1_data}, 32'hAA);
    step();
    finishEx();

    $display("[TB] test 6: reset while busy");
    pushExp(3'd0, 8'h31, 8'h32, 4'h0, 3'd1, 4'd8);
    applyStimulus(4'h0, 4'd8, 3'd1, 1, 4'd0, 8'h31, 1, 4'd0, 8'h32);
    applyStimulus(4'h1, 4'd9, 3'd2, 0, 4'd12, 8'h00, 1, 4'd0, 8'h05);
    applyStimulus(4'h0, 4'd10, 3'd3, 1, 4'd0, 8'h06, 0, 4'd12, 8'h00);
    checkOutput("t6_busy_count", {29'd0, add_count}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_rst_count", {29'd0, add_count}, 32'd0);
    checkOutput("t6_rst_outputs", {rs1_data, rs2_data, func, rd, ex_b, 1'b0, rob_ind, rs_index}, 32'd0);
    ex_done = 1'b1; cdb_valid = 1'b1; cdb_rd = 4'd12; cdb_data = 8'h77;
    step();
    ex_done = 1'b0; cdb_valid = 1'b0;
    step();
    checkOutput("t6_no_stale_ex_b", {31'd0, ex_b}, 32'd0);
    checkOutput("t6_still_empty", {29'd0, add_count}, 32'd0);
    pushExp(3'd0, 8'h40, 8'h41, 4'h1, 3'd7, 4'd11);
    applyStimulus(4'h1, 4'd11, 3'd7, 1, 4'd0, 8'h40, 1, 4'd0, 8'h41);
    step();
    checkOutput("t6_new_ex_b", {31'd0, ex_b}, 32'd1);
    step();
    finishEx();

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
